boundary_feeder: RTL and testbench
==================================

# boundary_feeder

Producer side of the boundary array: accepts boundary words from the CPU-side register interface, buffers them in a small FIFO, and drives the shift-in port (enable, direction, data) of the boundary shift array. After reset it primes the array with one word per cycle; afterwards it issues one shift each time the per-frame scroll accumulator crosses a row boundary. It also exports the sub-row fine offset used by the renderer for smooth scrolling.

## Interface
- DATA_W, 10, width of one boundary word; matches the array word width
- DEPTH, 8, FIFO entries; power of two, ≥ 2
- ARRAY_LEN, 30, rows shifted in during priming
- ROW_H, 16, scanlines per boundary row; power of two
- SPD_W, 3, width of speed; 2**SPD_W − 1 < ROW_H

- clk  in  1  clock
- reset  in  1  synchronous, active-low
- wr_valid  in  1  CPU offers a word
- wr_data  in  DATA_W  boundary word
- wr_ready  out  1  FIFO can accept; write occurs when wr_valid && wr_ready
- scroll_tick  in  1  one-cycle pulse per frame
- speed  in  SPD_W  scanlines scrolled per tick; sampled with scroll_tick
- pause  in  1  level; freezes scrolling
- shift_en  out  1  one-cycle shift strobe to the array
- shift_dir  out  1  constant 0 (new word enters at the low end)
- shift_data  out  DATA_W  word shifted in; valid while shift_en = 1
- fine_offset  out  clog2(ROW_H)  sub-row scroll position
- level  out  clog2(DEPTH)+1  FIFO occupancy
- prime_done  out  1  high once priming is complete
- underflow  out  1  sticky; set on a RUN shift with an empty FIFO
- underflow_clr  in  1  clears underflow

## Operation
- Reset (reset = 0 at a clk edge): FIFO empty, state PRIME, prime counter 0, fine_offset 0, shift_en 0, shift_dir 0, shift_data 0, last-word register 0, level 0, prime_done 0, underflow 0. wr_ready = 0 while reset is low.
- wr_ready = !full. A write while full is dropped; a pop freed in the same cycle does not make room (no full bypass).
- PRIME: each cycle with the FIFO non-empty → pop, shift_en = 1, shift_data = head word, counter++. When the counter reaches ARRAY_LEN → RUN, prime_done = 1. An empty FIFO stalls priming without setting underflow. scroll_tick and pause are ignored.
- RUN: on scroll_tick, sum = fine_offset + speed (width clog2(ROW_H)+1).
  - If sum ≥ ROW_H: fine_offset ← sum − ROW_H and one shift is issued.
  - Otherwise: fine_offset ← sum.
  - speed = 0 → no change. At most one shift per tick.
- RUN shift with a non-empty FIFO: pop the head and output it. With the FIFO empty: output the last-word register (repeats the previous row) and set underflow.
- The last-word register is updated on every issued shift.
- pause = 1 in RUN → HOLD: ticks are ignored and fine_offset is frozen. pause = 0 → RUN next cycle.
- Simultaneous events:
  - Write into an empty FIFO in the same cycle as a required pop → the pop sees empty (no empty bypass).
  - Write and pop when non-empty and not full → level unchanged.
  - underflow_clr in the same cycle as a new underflow event → underflow stays set.
- Reset mid-operation discards FIFO contents and restarts priming.

## Timing
- shift_en, shift_data, fine_offset, level, prime_done and underflow are all registered.
- A tick sampled at edge N → fine_offset updated and shift_en high in the cycle following edge N (1-cycle latency).
- A write at edge N → level increments after edge N; the word can be popped at edge N+1 at the earliest.
- Priming with a pre-filled FIFO: ARRAY_LEN back-to-back shift_en cycles, then prime_done rises on the edge of the last pop.

## Structure
- Package boundary_pkg holds:
  - state enum {PRIME, RUN, HOLD}
  - default constants DATA_W, ROW_H, ARRAY_LEN
- Sub-module boundary_fifo: synchronous FIFO with push, pop, full, empty and level, using pointer wrap on power-of-two DEPTH.
- The FSM, accumulator and output registers live in the top module.

## Test plan
- Priming: reset, write 30 words 0x001…0x01E with writes starting before priming begins → 30 shift_en pulses carrying 0x001…0x01E in order, shift_dir = 0, prime_done high after the last one.
- Accumulator: in RUN, ROW_H = 16, speed = 5 for 4 ticks → fine_offset 5, 10, 15, 4; exactly one shift_en, on the 4th tick.
- Underflow: FIFO empty in RUN and a shift is required → shift_data repeats the previous word, underflow = 1. Pulse underflow_clr → underflow = 0.
- Full: write 9 words with no pops (DEPTH = 8) → wr_ready = 0 after the 8th write, the 9th word is dropped, level = 8.
- Pause: pause = 1 for 3 ticks → no shifts and fine_offset unchanged. Release pause → the next tick accumulates normally.
- Reset mid-RUN with level = 5 → level = 0, state PRIME, fine_offset = 0, shift_data = 0.

Source files
------------

// File: rtl/boundary_pkg.sv
// Shared types and default sizing for the boundary feeder slice.
// Contents: FSM state encoding, default word width, row height, array length,
//   FIFO depth and speed width used as parameter defaults by boundary_feeder.

package boundary_pkg;

   typedef enum logic [1:0] {
      PRIME = 2'd0,   // filling the array after reset, one word per cycle
      RUN   = 2'd1,   // scroll-driven shifting
      HOLD  = 2'd2    // scrolling frozen by pause
   } state_t;

   localparam int DEF_DATA_W    = 10;
   localparam int DEF_DEPTH     = 8;
   localparam int DEF_ARRAY_LEN = 30;
   localparam int DEF_ROW_H     = 16;
   localparam int DEF_SPD_W     = 3;

endpackage

// File: rtl/boundary_fifo.sv
// Synchronous FIFO for boundary words; power-of-two depth, pointers wrap naturally.
// Ports: push_i/push_dat_i write side, pop_i/pop_dat_o read side (head is
//   combinational from storage), full_o/empty_o/level_o from registered state.
// Latency: a pushed word is visible at the head one cycle after the push edge.
// Backpressure: push while full and pop while empty are ignored; flags come from
//   registered occupancy only, so there is no full or empty bypass.

module boundary_fifo #(
   parameter int DATA_W = 10,
   parameter int DEPTH  = 8,
   parameter int AW     = $clog2(DEPTH),
   parameter int LW     = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push_i,
   input  logic [DATA_W-1:0] push_dat_i,
   input  logic              pop_i,
   output logic [DATA_W-1:0] pop_dat_o,
   output logic              full_o,
   output logic              empty_o,
   output logic [LW-1:0]     level_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q;
   logic [AW-1:0]     rd_ptr_q;
   logic [LW-1:0]     level_q;

   logic push_ok;
   logic pop_ok;

   assign full_o    = (level_q == LW'(DEPTH));
   assign empty_o   = (level_q == '0);
   assign push_ok   = push_i && !full_o;
   assign pop_ok    = pop_i && !empty_o;
   assign pop_dat_o = mem_q[rd_ptr_q];
   assign level_o   = level_q;

   // Storage carries no reset; only pointers and occupancy define validity.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= push_dat_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

endmodule

// File: rtl/boundary_feeder.sv
// Producer for the boundary shift array: buffers CPU words, primes the array,
//   then shifts one word in each time the scroll accumulator crosses a row.
// Ports: wr_valid_i/wr_dat_i/wr_ready_o CPU write; scroll_tick_i/speed_i/pause_i
//   scroll control; shift_en_o/shift_dir_o/shift_data_o array port;
//   fine_offset_o, level_o, prime_done_o, underflow_o (sticky)/underflow_clr_i status.
// Latency: tick or pop at edge N shows on the registered outputs after edge N.
// Backpressure: wr_ready_o = !full (low during reset); an empty FIFO stalls
//   priming, while a RUN shift on empty repeats the last word and flags underflow.

module boundary_feeder
   import boundary_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int ARRAY_LEN = DEF_ARRAY_LEN,
   parameter int ROW_H     = DEF_ROW_H,
   parameter int SPD_W     = DEF_SPD_W,
   parameter int FW        = $clog2(ROW_H),
   parameter int LW        = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_valid_i,
   input  logic [DATA_W-1:0] wr_data_i,
   output logic              wr_ready_o,
   input  logic              scroll_tick_i,
   input  logic [SPD_W-1:0]  speed_i,
   input  logic              pause_i,
   output logic              shift_en_o,
   output logic              shift_dir_o,
   output logic [DATA_W-1:0] shift_data_o,
   output logic [FW-1:0]     fine_offset_o,
   output logic [LW-1:0]     level_o,
   output logic              prime_done_o,
   output logic              underflow_o,
   input  logic              underflow_clr_i
);

   localparam int          CNT_W   = $clog2(ARRAY_LEN + 1);
   localparam logic [FW:0] ROW_SUM = (FW + 1)'(ROW_H);

   state_t              state_q;
   logic [CNT_W-1:0]    prime_cnt_q;
   logic [FW-1:0]       fine_q;
   logic                shift_en_q;
   logic [DATA_W-1:0]   shift_data_q;
   logic [DATA_W-1:0]   last_word_q;
   logic                prime_done_q;
   logic                underflow_q;

   logic                fifo_full;
   logic                fifo_empty;
   logic [DATA_W-1:0]   fifo_head;
   logic                fifo_push;

   logic [FW:0]         sum_d;
   logic [FW-1:0]       fine_d;
   logic                run_tick;
   logic                shift_req;
   logic                pop_req;
   logic                uf_evt;
   logic [DATA_W-1:0]   shift_data_d;

   assign wr_ready_o = reset && !fifo_full;
   assign fifo_push  = wr_valid_i && wr_ready_o;

   boundary_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push_i     (fifo_push),
      .push_dat_i (wr_data_i),
      .pop_i      (pop_req),
      .pop_dat_o  (fifo_head),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .level_o    (level_o)
   );

   // Accumulator: one extra bit catches the row crossing; speed < ROW_H
   // guarantees at most one crossing per tick.
   always_comb begin
      sum_d        = {1'b0, fine_q} + (FW + 1)'(speed_i);
      fine_d       = sum_d[FW-1:0];
      run_tick     = 1'b0;
      shift_req    = 1'b0;
      pop_req      = 1'b0;
      uf_evt       = 1'b0;
      shift_data_d = fifo_head;

      if (sum_d >= ROW_SUM) begin
         fine_d = FW'(sum_d - ROW_SUM);
      end

      case (state_q)
         PRIME: begin
            pop_req = !fifo_empty;
         end
         RUN: begin
            run_tick  = scroll_tick_i && !pause_i;
            shift_req = run_tick && (sum_d >= ROW_SUM);
            pop_req   = shift_req && !fifo_empty;
            uf_evt    = shift_req && fifo_empty;
         end
         default: ;
      endcase

      // Starved RUN shift repeats the previous row.
      if (fifo_empty) begin
         shift_data_d = last_word_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= PRIME;
         prime_cnt_q  <= '0;
         fine_q       <= '0;
         shift_en_q   <= 1'b0;
         shift_data_q <= '0;
         last_word_q  <= '0;
         prime_done_q <= 1'b0;
         underflow_q  <= 1'b0;
      end else begin
         shift_en_q <= 1'b0;

         // A new event outranks a same-cycle clear.
         if (uf_evt) begin
            underflow_q <= 1'b1;
         end else if (underflow_clr_i) begin
            underflow_q <= 1'b0;
         end

         case (state_q)
            PRIME: begin
               if (pop_req) begin
                  shift_en_q   <= 1'b1;
                  shift_data_q <= fifo_head;
                  last_word_q  <= fifo_head;
                  if (prime_cnt_q == CNT_W'(ARRAY_LEN - 1)) begin
                     state_q      <= RUN;
                     prime_done_q <= 1'b1;
                  end
                  prime_cnt_q <= prime_cnt_q + 1'b1;
               end
            end
            RUN: begin
               if (pause_i) begin
                  state_q <= HOLD;
               end else if (run_tick) begin
                  fine_q <= fine_d;
                  if (shift_req) begin
                     shift_en_q   <= 1'b1;
                     shift_data_q <= shift_data_d;
                     last_word_q  <= shift_data_d;
                  end
               end
            end
            HOLD: begin
               if (!pause_i) begin
                  state_q <= RUN;
               end
            end
            default: begin
               state_q <= PRIME;
            end
         endcase
      end
   end

   assign shift_en_o    = shift_en_q;
   assign shift_dir_o   = 1'b0;
   assign shift_data_o  = shift_data_q;
   assign fine_offset_o = fine_q;
   assign prime_done_o  = prime_done_q;
   assign underflow_o   = underflow_q;

endmodule

// File: tb/tb_boundary_feeder.sv
// Directed bench for boundary_feeder: priming, accumulator, underflow, pause,
//   full FIFO, simultaneous push/pop and mid-run reset with hand-computed values.

module tb_boundary_feeder;

   logic       clk;
   logic       reset;
   logic       wr_valid;
   logic [9:0] wr_data;
   logic       wr_ready;
   logic       scroll_tick;
   logic [2:0] speed;
   logic       pause;
   logic       shift_en;
   logic       shift_dir;
   logic [9:0] shift_data;
   logic [3:0] fine_offset;
   logic [3:0] level;
   logic       prime_done;
   logic       underflow;
   logic       underflow_clr;

   int checks = 0;
   int errors = 0;
   int pcnt   = 0;

   typedef struct packed {
      logic [2:0] spd;
      logic       clr;
      logic       wr;
      logic [9:0] wd;
      logic [3:0] fo;
      logic       se;
      logic [9:0] sd;
      logic       uf;
      logic [3:0] lv;
   } vec_t;

   // Starts with fine=0, FIFO holding 0x0AA,0x0BB, last word 0x01E.
   vec_t acc_tab [14] = '{
      '{3'd5, 1'b0, 1'b0, 10'h000, 4'd5,  1'b0, 10'h000, 1'b0, 4'd2},
      '{3'd5, 1'b0, 1'b0, 10'h000, 4'd10, 1'b0, 10'h000, 1'b0, 4'd2},
      '{3'd5, 1'b0, 1'b0, 10'h000, 4'd15, 1'b0, 10'h000, 1'b0, 4'd2},
      '{3'd5, 1'b0, 1'b0, 10'h000, 4'd4,  1'b1, 10'h0AA, 1'b0, 4'd1},
      '{3'd0, 1'b0, 1'b0, 10'h000, 4'd4,  1'b0, 10'h000, 1'b0, 4'd1},
      '{3'd7, 1'b0, 1'b0, 10'h000, 4'd11, 1'b0, 10'h000, 1'b0, 4'd1},
      '{3'd7, 1'b0, 1'b0, 10'h000, 4'd2,  1'b1, 10'h0BB, 1'b0, 4'd0},
      '{3'd7, 1'b0, 1'b0, 10'h000, 4'd9,  1'b0, 10'h000, 1'b0, 4'd0},
      '{3'd7, 1'b0, 1'b0, 10'h000, 4'd0,  1'b1, 10'h0BB, 1'b1, 4'd0},
      '{3'd0, 1'b1, 1'b0, 10'h000, 4'd0,  1'b0, 10'h000, 1'b0, 4'd0},
      '{3'd7, 1'b0, 1'b0, 10'h000, 4'd7,  1'b0, 10'h000, 1'b0, 4'd0},
      '{3'd7, 1'b0, 1'b0, 10'h000, 4'd14, 1'b0, 10'h000, 1'b0, 4'd0},
      '{3'd7, 1'b1, 1'b0, 10'h000, 4'd5,  1'b1, 10'h0BB, 1'b1, 4'd0},
      '{3'd0, 1'b1, 1'b0, 10'h000, 4'd5,  1'b0, 10'h000, 1'b0, 4'd0}
   };

   // Starts with fine=12, FIFO full with 0x100..0x107.
   vec_t full_tab [9] = '{
      '{3'd7, 1'b0, 1'b1, 10'h1FF, 4'd3,  1'b1, 10'h100, 1'b0, 4'd7},
      '{3'd7, 1'b0, 1'b0, 10'h000, 4'd10, 1'b0, 10'h000, 1'b0, 4'd7},
      '{3'd7, 1'b0, 1'b1, 10'h1EE, 4'd1,  1'b1, 10'h101, 1'b0, 4'd7},
      '{3'd7, 1'b0, 1'b0, 10'h000, 4'd8,  1'b0, 10'h000, 1'b0, 4'd7},
      '{3'd7, 1'b0, 1'b0, 10'h000, 4'd15, 1'b0, 10'h000, 1'b0, 4'd7},
      '{3'd2, 1'b0, 1'b0, 10'h000, 4'd1,  1'b1, 10'h102, 1'b0, 4'd6},
      '{3'd7, 1'b0, 1'b0, 10'h000, 4'd8,  1'b0, 10'h000, 1'b0, 4'd6},
      '{3'd7, 1'b0, 1'b0, 10'h000, 4'd15, 1'b0, 10'h000, 1'b0, 4'd6},
      '{3'd1, 1'b0, 1'b0, 10'h000, 4'd0,  1'b1, 10'h103, 1'b0, 4'd5}
   };

   boundary_feeder dut (
      .clk             (clk),
      .reset           (reset),
      .wr_valid_i      (wr_valid),
      .wr_data_i       (wr_data),
      .wr_ready_o      (wr_ready),
      .scroll_tick_i   (scroll_tick),
      .speed_i         (speed),
      .pause_i         (pause),
      .shift_en_o      (shift_en),
      .shift_dir_o     (shift_dir),
      .shift_data_o    (shift_data),
      .fine_offset_o   (fine_offset),
      .level_o         (level),
      .prime_done_o    (prime_done),
      .underflow_o     (underflow),
      .underflow_clr_i (underflow_clr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [9:0] wd);
      wr_valid = 1'b1;
      wr_data  = wd;
      @(negedge clk);
      wr_valid = 1'b0;
   endtask

   // Drives one tick cycle; outputs are sampled at the following negedge.
   task automatic tick(input logic [2:0] spd, input logic clr, input logic wr,
                       input logic [9:0] wd);
      scroll_tick   = 1'b1;
      speed         = spd;
      underflow_clr = clr;
      wr_valid      = wr;
      wr_data       = wd;
      @(negedge clk);
      scroll_tick   = 1'b0;
      speed         = 3'd0;
      underflow_clr = 1'b0;
      wr_valid      = 1'b0;
   endtask

   task automatic run_vec(input string tag, input vec_t v);
      tick(v.spd, v.clr, v.wr, v.wd);
      chk({tag, "_fine"}, 32'(fine_offset), 32'(v.fo));
      chk({tag, "_sen"},  32'(shift_en),    32'(v.se));
      chk({tag, "_uf"},   32'(underflow),   32'(v.uf));
      chk({tag, "_lvl"},  32'(level),       32'(v.lv));
      if (v.se) begin
         chk({tag, "_sdat"}, 32'(shift_data), 32'(v.sd));
      end
   endtask

   initial begin
      reset         = 1'b0;
      wr_valid      = 1'b0;
      wr_data       = '0;
      scroll_tick   = 1'b0;
      speed         = '0;
      pause         = 1'b0;
      underflow_clr = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_level",  32'(level),       32'd0);
      chk("rst_sen",    32'(shift_en),    32'd0);
      chk("rst_sdat",   32'(shift_data),  32'd0);
      chk("rst_fine",   32'(fine_offset), 32'd0);
      chk("rst_pdone",  32'(prime_done),  32'd0);
      chk("rst_uf",     32'(underflow),   32'd0);
      chk("rst_wrrdy",  32'(wr_ready),    32'd0);
      chk("rst_dir",    32'(shift_dir),   32'd0);

      // Priming: writes offered while reset is still low, then one per cycle.
      wr_valid = 1'b1;
      wr_data  = 10'h001;
      reset    = 1'b1;
      fork
         begin
            for (int i = 1; i <= 30; i++) begin
               wr_valid = 1'b1;
               wr_data  = 10'(i);
               @(negedge clk);
            end
            wr_valid = 1'b0;
         end
         begin
            for (int c = 0; c < 200 && pcnt < 30; c++) begin
               @(negedge clk);
               if (shift_en) begin
                  chk("prime_sdat", 32'(shift_data), 32'(pcnt + 1));
                  chk("prime_dir",  32'(shift_dir),  32'd0);
                  if (pcnt == 0) begin
                     chk("prime_pdone_early", 32'(prime_done), 32'd0);
                  end
                  pcnt++;
               end
            end
            chk("prime_count", 32'(pcnt), 32'd30);
            chk("prime_pdone", 32'(prime_done), 32'd1);
         end
      join

      push(10'h0AA);
      push(10'h0BB);
      chk("pre_acc_level", 32'(level), 32'd2);

      for (int i = 0; i < 14; i++) begin
         run_vec($sformatf("acc%0d", i), acc_tab[i]);
      end

      // Pause: ticks ignored while held, then accumulation resumes.
      pause = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         tick(3'd7, 1'b0, 1'b0, 10'h000);
         chk($sformatf("pause%0d_fine", i), 32'(fine_offset), 32'd5);
         chk($sformatf("pause%0d_sen", i),  32'(shift_en),    32'd0);
      end
      pause = 1'b0;
      @(negedge clk);
      tick(3'd7, 1'b0, 1'b0, 10'h000);
      chk("unpause_fine", 32'(fine_offset), 32'd12);
      chk("unpause_sen",  32'(shift_en),    32'd0);

      // Full: nine writes with no pops, the ninth is dropped.
      for (int i = 0; i < 9; i++) begin
         wr_valid = 1'b1;
         wr_data  = 10'h100 + 10'(i);
         @(negedge clk);
         if (i == 6) chk("full_rdy7", 32'(wr_ready), 32'd1);
         if (i == 7) chk("full_rdy8", 32'(wr_ready), 32'd0);
      end
      wr_valid = 1'b0;
      chk("full_level", 32'(level), 32'd8);

      for (int i = 0; i < 9; i++) begin
         run_vec($sformatf("full%0d", i), full_tab[i]);
      end

      // Mid-run reset with five words buffered.
      reset = 1'b0;
      @(negedge clk);
      chk("mrst_level", 32'(level),       32'd0);
      chk("mrst_fine",  32'(fine_offset), 32'd0);
      chk("mrst_sdat",  32'(shift_data),  32'd0);
      chk("mrst_pdone", 32'(prime_done),  32'd0);
      chk("mrst_sen",   32'(shift_en),    32'd0);
      reset = 1'b1;
      @(negedge clk);
      push(10'h155);
      chk("mrst_level1", 32'(level), 32'd1);
      @(negedge clk);
      chk("reprime_sen",   32'(shift_en),   32'd1);
      chk("reprime_sdat",  32'(shift_data), 32'h155);
      chk("reprime_pdone", 32'(prime_done), 32'd0);
      chk("reprime_level", 32'(level),      32'd0);
      tick(3'd7, 1'b0, 1'b0, 10'h000);
      chk("prime_tick_fine", 32'(fine_offset), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
